pipe_stage_latch: RTL
=====================

# pipe_stage_latch

Parametrised pipeline-stage register for the five-stage processor, replacing the fixed per-stage latches (F/D, D/X, X/M, M/W) with one configurable block. Carries one instruction word plus NCH data channels of WIDTH bits, a valid bit and an exception flag. Supports stall (hold), flush (bubble insertion) and a saturating stall-cycle counter for performance monitoring. One instance sits between each pair of adjacent stages.

## Interface
Parameters:
- WIDTH, 32, width of the instruction word and of each data channel
- NCH, 2, number of data channels (1..8)
- CNT_W, 16, stall-counter width
- NOP_INSN, 32'h0000_0000, instruction word loaded on reset/flush

Ports:
- clock  in  1  rising-edge clock; the block's only clock
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock
- en  in  1  load enable; 0 = stall (hold all state)
- flush  in  1  replace stage contents with a bubble
- validIn  in  1  incoming instruction is real
- insnIn  in  WIDTH  incoming instruction
- dataIn  in  NCH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- excIn  in  1  exception raised upstream for this instruction
- validOut  out  1  registered valid
- insnOut  out  WIDTH  registered instruction
- dataOut  out  NCH*WIDTH  registered channels, same packing as dataIn
- excOut  out  1  registered exception flag
- stallCount  out  CNT_W  cycles spent stalled while holding a valid instruction

## Operation
- All state updates on rising clock edge only; outputs come directly from registers (no combinational in->out path).
- Priority per edge: reset > flush > en > hold.
- reset=1: validOut=0, insnOut=NOP_INSN, every dataOut channel=0, excOut=0, stallCount=0.
- flush=1 (reset=0): validOut=0, insnOut=NOP_INSN, dataOut=0, excOut=0, regardless of en. stallCount unchanged.
- en=1, flush=0: validOut<=validIn, insnOut<=insnIn, dataOut<=dataIn, excOut<=excIn & validIn (an exception on an invalid slot is dropped).
- en=0, flush=0: all data/valid/exc registers hold. If validOut=1, stallCount increments by 1, saturating at 2^CNT_W-1 (never wraps). If validOut=0, stallCount holds.
- Each data channel is loaded from its own dataIn slice; no channel feeds back into itself or another channel.
- stallCount is cleared only by reset.

## Timing
- Latency: exactly 1 cycle from input sampled (en=1) to output visible.
- Throughput: one instruction per cycle when en=1 continuously.
- Stall: outputs bit-for-bit stable for every cycle en=0; first new value appears the cycle after en returns to 1.
- Flush while stalled (en=0, flush=1): bubble loaded that edge; flush wins.
- Reset mid-stall or mid-flush: reset result that edge; subsequent behaviour as from power-up.
- Counter saturation: at 2^CNT_W-1 with further stall cycles, value stays at 2^CNT_W-1.

## Configuration
- Macro PIPE_STAGE_EXC_EN.
- Defined: excIn registered into excOut as described; flush and reset clear it.
- Not defined: no exception register is built; excIn ignored; excOut tied to constant 0. All other behaviour identical.

## Test plan
- Reset: drive reset=1 for 2 cycles with insnIn=32'hDEADBEEF, validIn=1, en=1 -> validOut=0, insnOut=32'h0, dataOut=0, excOut=0, stallCount=0.
- Pass-through, NCH=2: en=1, insnIn=32'h12345678, dataIn={32'hAAAA0001,32'h5555_0002}, validIn=1 -> one cycle later insnOut=32'h12345678, channel1=32'hAAAA0001, channel0=32'h55550002, validOut=1; back-to-back changing inputs appear one per cycle.
- Stall: load valid insn 32'h1, then en=0 for 5 cycles with insnIn=32'h2 -> insnOut stays 32'h1, stallCount=5; en=1 -> insnOut=32'h2 next cycle, stallCount stays 5.
- Flush priority: en=0, flush=1 with validOut=1 -> next cycle validOut=0, insnOut=NOP_INSN, dataOut=0; further en=0 cycles leave stallCount unchanged.
- Exception (PIPE_STAGE_EXC_EN defined): excIn=1, validIn=1 -> excOut=1; excIn=1, validIn=0 -> excOut=0; without macro excOut=0 in both cases.
- Saturation: CNT_W=4, valid held, en=0 for 20 cycles -> stallCount reaches 15 at cycle 15 and stays 15.

Source files
------------

// File: rtl/pipe_stage_latch.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_latch
//  Description : Configurable pipeline-stage register. Holds one instruction
//                word, NCH data channels, a valid bit and an exception flag.
//                Supports stall (hold), flush (bubble insertion) and a
//                saturating stall-cycle counter.
//                Optional feature macro: PIPE_STAGE_EXC_EN. When it is
//                defined, the exception flag is registered. When it is not
//                defined, excOut is tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_latch #(
    parameter int              WIDTH    = 32,
    parameter int              NCH      = 2,
    parameter int              CNT_W    = 16,
    parameter logic [WIDTH-1:0] NOP_INSN = {WIDTH{1'b0}}
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 validIn,
    input  logic [WIDTH-1:0]     insnIn,
    input  logic [NCH*WIDTH-1:0] dataIn,
    input  logic                 excIn,
    output logic                 validOut,
    output logic [WIDTH-1:0]     insnOut,
    output logic [NCH*WIDTH-1:0] dataOut,
    output logic                 excOut,
    output logic [CNT_W-1:0]     stallCount
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                 r_valid;
    logic [WIDTH-1:0]     r_insn;
    logic [NCH*WIDTH-1:0] r_data;
    logic [CNT_W-1:0]     r_stallCnt;

    // A stall cycle counts only while a real instruction is being held.
    logic w_stallCycle;
    assign w_stallCycle = !flush && !en && r_valid;

    // Valid bit and instruction word: reset/flush insert a bubble, en loads.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_valid <= 1'b0;
            r_insn  <= NOP_INSN;
        end else if (en) begin
            r_valid <= validIn;
            r_insn  <= insnIn;
        end
    end

    // One independent register per data channel, each fed only by its slice.
    generate
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            always_ff @(posedge clock) begin
                if (reset || flush) begin
                    r_data[k*WIDTH +: WIDTH] <= {WIDTH{1'b0}};
                end else if (en) begin
                    r_data[k*WIDTH +: WIDTH] <= dataIn[k*WIDTH +: WIDTH];
                end
            end
        end
    endgenerate

`ifdef PIPE_STAGE_EXC_EN
    logic r_exc;

    // Exception flag; an exception attached to an invalid slot is dropped.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_exc <= 1'b0;
        end else if (en) begin
            r_exc <= excIn & validIn;
        end
    end

    assign excOut = r_exc;
`else
    // No exception register in this build; the input is deliberately unused.
    logic w_unusedExc;
    assign w_unusedExc = excIn;
    assign excOut      = 1'b0;
`endif

    // Stall counter: cleared only by reset, saturates instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stallCnt <= {CNT_W{1'b0}};
        end else if (w_stallCycle && (r_stallCnt != c_CNT_MAX)) begin
            r_stallCnt <= r_stallCnt + c_CNT_ONE;
        end
    end

    assign validOut   = r_valid;
    assign insnOut    = r_insn;
    assign dataOut    = r_data;
    assign stallCount = r_stallCnt;

endmodule
`default_nettype wire
